// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order memory requests,
// queues returned words with their PCs for decode, and handles redirects and halt.
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              FIFO_DEPTH   = 4,
    parameter logic [31:0]     HALT_WORD    = 32'hFFFF_FFFF
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_data,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            halted
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int CSW = CW + 1;
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] PC_ALIGN = ~XLEN'(3);
    localparam logic [CSW-1:0]  DEPTH_W  = CSW'(FIFO_DEPTH);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [31:0]     r_q_data [FIFO_DEPTH];
    logic [XLEN-1:0] r_q_pc   [FIFO_DEPTH];

    logic            w_run;
    logic            w_redirect;
    logic            w_req_fire;
    logic            w_resp;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_halt;
    logic [CSW-1:0]  w_credit_used;
    logic [CW-1:0]   w_out_next;
    logic [XLEN-1:0] w_target;

    // Requests in flight count against queue space, so every response has a slot.
    assign w_run         = (r_state == ST_RUN);
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, r_count};
    assign imem_req_valid = w_run & ~reset & ~redirect_valid & (w_credit_used < DEPTH_W);
    assign imem_req_addr  = r_fetch_pc;

    assign instr_valid = w_run & (r_count != '0);
    assign instr_data  = r_q_data[r_rd_ptr];
    assign instr_pc    = r_q_pc[r_rd_ptr];
    assign halted      = ~w_run;

    assign w_target   = redirect_target & PC_ALIGN;
    assign w_redirect = w_run & redirect_valid;
    assign w_req_fire = imem_req_valid & imem_req_ready;
    assign w_resp     = imem_resp_valid & (r_outstanding != '0);
    assign w_drop     = w_resp & (r_drop_cnt != '0);
    assign w_push     = w_resp & ~w_drop & w_run & ~redirect_valid;
    assign w_pop      = instr_valid & instr_ready & ~redirect_valid;
    assign w_halt     = w_pop & (instr_data == HALT_WORD);
    assign w_out_next = r_outstanding + CW'(w_req_fire) - CW'(w_resp);

    // NOTE: next state gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        if (w_run && w_halt) begin
            w_state_next = ST_HALTED;
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc    <= RESET_VECTOR;
            r_resp_pc     <= RESET_VECTOR;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_redirect) begin
                // Everything still in flight belongs to the abandoned path.
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_drop_cnt <= w_out_next;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else if (w_halt) begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
                r_drop_cnt <= w_out_next;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_push) begin
                    r_wr_ptr  <= r_wr_ptr + PW'(1);
                    r_resp_pc <= r_resp_pc + PC_STEP;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // NOTE: queue storage is reset too, so the head outputs read zero out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else if (w_push) begin
            r_q_data[r_wr_ptr] <= imem_resp_data;
            r_q_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random memory/decode/redirect stimulus against an
// architectural model of the expected instruction stream, plus a wrap-around instance.
module tb_fetch_unit;

    localparam logic [31:0] RV      = 32'h0000_0000;
    localparam logic [31:0] WRAP_RV = 32'hFFFF_FFF8;
    localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

    logic        clock;
    logic        reset = 1'b1;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_data, instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halted;

    logic        w_req_valid, w_resp_valid, w_instr_valid, w_halted;
    logic [31:0] w_req_addr, w_resp_data, w_instr_data, w_instr_pc;

    fetch_unit dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halted(halted)
    );

    fetch_unit #(.RESET_VECTOR(WRAP_RV)) u_wrap (
        .clock(clock), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(w_req_addr), .imem_resp_valid(w_resp_valid),
        .imem_resp_data(w_resp_data), .instr_valid(w_instr_valid),
        .instr_ready(1'b1), .instr_data(w_instr_data), .instr_pc(w_instr_pc),
        .redirect_valid(1'b0), .redirect_target(32'h0),
        .halted(w_halted)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Knobs for the random environment
    int rr_pct    = 100;
    int lat_min   = 1;
    int lat_max   = 1;
    int ir_pct    = 100;
    int redir_pct = 0;
    logic [31:0] halt_addr = 32'h1;

    // Reference model: the architectural instruction stream the decoder should see
    logic [31:0] exp_q[$];
    logic [31:0] exp_next;
    bit          model_halted = 1'b0;
    int          del_cnt = 0;

    // Memory model state
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc = 0;
    int          last_due = 0;
    int          acc_cnt = 0;
    int          acc_base = 0;
    logic [31:0] last_acc_addr = '0;
    bit          mem_rst = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] addr);
        return (addr == halt_addr) ? HALT : {addr[29:0], 2'b01};
    endfunction

    task automatic exp_topup();
        while (exp_q.size() < 32) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
        end
    endtask

    task automatic exp_restart(input logic [31:0] start);
        exp_q.delete();
        exp_next = start;
        exp_topup();
    endtask

    // Instruction memory: random accept, in-order responses after random latency
    initial begin
        int due;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clock);
            mem_rst = reset;
            if (!reset && imem_req_valid && imem_req_ready) begin
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(due);
                acc_cnt++;
                last_acc_addr = imem_req_addr;
            end
            @(posedge clock);
            #1;
            cyc++;
            imem_resp_valid = 1'b0;
            if (mem_rst) begin
                pend_addr.delete();
                pend_due.delete();
            end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = word(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            imem_req_ready = ($urandom_range(99, 0) < rr_pct);
        end
    end

    // Decode/execute driver: random decode stalls and redirects
    initial begin
        logic [31:0] tgt;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        exp_restart(RV);
        forever begin
            @(posedge clock);
            #1;
            instr_ready    = ($urandom_range(99, 0) < ir_pct);
            redirect_valid = 1'b0;
            if (!reset && !model_halted && ($urandom_range(99, 0) < redir_pct)) begin
                if ($urandom_range(7, 0) == 0) tgt = 32'hFFFF_FFF0 | $urandom_range(15, 0);
                else                           tgt = $urandom_range(255, 0);
                redirect_valid  = 1'b1;
                redirect_target = tgt;
                exp_restart({tgt[31:2], 2'b00});
            end
            exp_topup();
        end
    end

    // Monitor: pops expected entries whenever decode consumes an instruction
    always @(negedge clock) begin
        logic [31:0] e;
        if (!reset) begin
            check("halted_state", halted, model_halted);
            if (model_halted) begin
                check("halt_req_valid", imem_req_valid, 1'b0);
                check("halt_instr_valid", instr_valid, 1'b0);
            end
            if (redirect_valid) check("redir_no_req", imem_req_valid, 1'b0);
            if (instr_valid && instr_ready && !redirect_valid) begin
                del_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_underflow: got pc %h, expected no delivery", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", instr_pc, e);
                    check("sb_data", instr_data, word(e));
                    if (word(e) == HALT) model_halted = 1'b1;
                end
            end
        end
    end

    // Wrap-around instance: zero-wait memory, decode always ready
    initial begin
        logic        acc;
        logic [31:0] acc_addr;
        logic [31:0] w_exp;
        acc = 1'b0;
        acc_addr = '0;
        w_exp = WRAP_RV;
        w_resp_valid = 1'b0;
        w_resp_data  = '0;
        forever begin
            @(negedge clock);
            acc      = !reset && w_req_valid;
            acc_addr = w_req_addr;
            if (reset) begin
                w_exp = WRAP_RV;
            end else if (w_instr_valid) begin
                check("wrap_pc", w_instr_pc, w_exp);
                check("wrap_data", w_instr_data, {w_exp[29:0], 2'b01});
                w_exp = w_exp + 32'd4;
            end
            @(posedge clock);
            #1;
            w_resp_valid = acc;
            w_resp_data  = {acc_addr[29:0], 2'b01};
        end
    end

    task automatic do_reset(input bit chk);
        @(posedge clock);
        #2;
        reset = 1'b1;
        model_halted = 1'b0;
        exp_restart(RV);
        @(posedge clock);
        @(posedge clock);
        if (chk) begin
            @(negedge clock);
            #1;
            check("rst_req_valid", imem_req_valid, 1'b0);
            check("rst_req_addr", imem_req_addr, RV);
            check("rst_instr_valid", instr_valid, 1'b0);
            check("rst_instr_pc", instr_pc, 32'h0);
            check("rst_instr_data", instr_data, 32'h0);
            check("rst_halted", halted, 1'b0);
            check("rst_wrap_addr", w_req_addr, WRAP_RV);
            check("rst_wrap_valid", w_instr_valid, 1'b0);
            @(posedge clock);
        end
        #2;
        reset    = 1'b0;
        acc_base = acc_cnt;
        del_cnt  = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int n_valid;
        int d0;
        int base;

        // In-order stream from reset with zero stalls and 1-cycle memory
        do_reset(1'b1);
        @(negedge clock);
        #1;
        check("first_req_valid", imem_req_valid, 1'b1);
        check("first_req_addr", imem_req_addr, RV);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clock);
            #1;
            if (instr_valid) found = 1'b1;
        end
        check("fill_seen", found, 1'b1);
        n_valid = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            #1;
            n_valid += int'(instr_valid);
        end
        check("stream_no_gaps", n_valid, 16);

        // Decode stalled: credit limits requests to the queue depth
        ir_pct = 0;
        do_reset(1'b0);
        repeat (15) @(negedge clock);
        #1;
        check("credit_req_count", acc_cnt - acc_base, 4);
        check("credit_req_stall", imem_req_valid, 1'b0);
        check("credit_queue_full", instr_valid, 1'b1);
        ir_pct = 100;
        repeat (20) @(posedge clock);
        check("credit_resume", del_cnt >= 15, 1'b1);

        // Redirect to an unaligned target with requests in flight
        lat_min = 2;
        lat_max = 2;
        do_reset(1'b0);
        repeat (6) @(posedge clock);
        #2;
        redirect_valid  = 1'b1;
        redirect_target = 32'h103;
        exp_restart(32'h100);
        base = acc_cnt;
        d0   = del_cnt;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clock);
            #1;
            if (acc_cnt != base) found = 1'b1;
        end
        check("redir_req_seen", found, 1'b1);
        check("redir_req_addr", last_acc_addr, 32'h100);
        repeat (10) @(posedge clock);
        check("redir_delivered", del_cnt > d0, 1'b1);

        // Redirect colliding with a response and a pending request
        lat_min = 1;
        lat_max = 1;
        do_reset(1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clock);
            #2;
            if (imem_resp_valid && imem_req_valid) begin
                found = 1'b1;
                redirect_valid  = 1'b1;
                redirect_target = 32'h200;
                exp_restart(32'h200);
            end
        end
        check("collide_seen", found, 1'b1);
        @(negedge clock);
        #1;
        check("collide_no_req", imem_req_valid, 1'b0);
        d0 = del_cnt;
        repeat (10) @(posedge clock);
        check("collide_delivered", del_cnt > d0, 1'b1);

        // Halt word at PC 8
        halt_addr = 32'h8;
        do_reset(1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            #1;
            if (halted) found = 1'b1;
        end
        check("halt_reached", found, 1'b1);
        check("halt_after_three", del_cnt, 3);
        repeat (8) @(negedge clock);
        @(posedge clock);
        #2;
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        @(posedge clock);
        #2;
        @(negedge clock);
        #1;
        check("halt_ignores_redirect", halted, 1'b1);
        check("halt_no_req_after_redir", imem_req_valid, 1'b0);

        // Randomised traffic with mid-stream resets, wrap targets and occasional halts
        rr_pct    = 75;
        lat_min   = 1;
        lat_max   = 4;
        ir_pct    = 70;
        redir_pct = 4;
        for (int blk = 0; blk < 6; blk++) begin
            halt_addr = (blk % 2 == 1) ? 32'h60 : 32'h1;
            do_reset(1'b1);
            repeat (400) @(posedge clock);
        end

        redir_pct = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
